// File: rtl/ram_io.sv
// Byte-wide RAM with a memory-mapped I/O window (TX/RX byte FIFOs, status, halt) at 0x3xxxx.
// Optional RX path is built only when IO_RX_EN is defined.
module ram_io #(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RWstate,
    input  logic [31:0] RWaddr,
    input  logic [7:0] WrtData,
    output logic [7:0] ReadData,
    output logic       io_tx_valid,
    output logic [7:0] io_tx_data,
    input  logic       io_tx_ready,
    input  logic       io_rx_valid,
    input  logic [7:0] io_rx_data,
    output logic       io_rx_ready,
    output logic       sim_halt
);
    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_PW + 1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic is_io;
    logic data_sel;
    logic ctrl_sel;
    logic [RAM_ADDR_W-1:0] ram_idx;

    assign is_io    = (RWaddr[17:16] == 2'b11);
    assign data_sel = is_io && (RWaddr[15:0] == 16'h0000);
    assign ctrl_sel = is_io && (RWaddr[15:0] == 16'h0004);
    assign ram_idx  = RWaddr[RAM_ADDR_W-1:0];

    wire unused_addr = &{1'b0, RWaddr};

    // ------------------------------------------------------------------
    // RAM array: never reset, so contents survive rst
    // ------------------------------------------------------------------
    logic [7:0] ram [0:(1<<RAM_ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (!is_io && RWstate)
            ram[ram_idx] <= WrtData;
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       tx_mem [0:TX_DEPTH-1];
    logic [TX_PW-1:0] tx_wr_ptr_reg;
    logic [TX_PW-1:0] tx_rd_ptr_reg;
    logic [TX_CW-1:0] tx_count_reg;
    logic [TX_CW-1:0] tx_count_next;
    logic             tx_overflow_reg;
    logic             sim_halt_reg;
    logic             tx_full;
    logic             tx_push_req;
    logic             tx_push;
    logic             tx_pop;

    assign tx_full     = (tx_count_reg == TX_CW'(TX_DEPTH));
    assign tx_push_req = data_sel && RWstate;
    assign tx_pop      = io_tx_valid && io_tx_ready;
    // A simultaneous pop frees a slot, so a push into a full FIFO is still taken
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);

    assign io_tx_valid = (tx_count_reg != '0);
    assign io_tx_data  = tx_mem[tx_rd_ptr_reg];
    assign sim_halt    = sim_halt_reg;

    always_comb begin
        tx_count_next = tx_count_reg;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count_reg + 1'b1;
            2'b01:   tx_count_next = tx_count_reg - 1'b1;
            default: tx_count_next = tx_count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr_reg] <= WrtData;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr_reg   <= '0;
            tx_rd_ptr_reg   <= '0;
            tx_count_reg    <= '0;
            tx_overflow_reg <= 1'b0;
            sim_halt_reg    <= 1'b0;
        end else begin
            tx_count_reg <= tx_count_next;
            if (tx_push)
                tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)
                tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            if (tx_push_req && tx_full && !tx_pop)
                tx_overflow_reg <= 1'b1;
            if (ctrl_sel && RWstate)
                sim_halt_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (optional)
    // ------------------------------------------------------------------
    logic       rx_nonempty;
    logic [7:0] rx_head;
    logic       rx_pop;

`ifdef IO_RX_EN
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_PW + 1;

    logic [7:0]       rx_mem [0:RX_DEPTH-1];
    logic [RX_PW-1:0] rx_wr_ptr_reg;
    logic [RX_PW-1:0] rx_rd_ptr_reg;
    logic [RX_CW-1:0] rx_count_reg;
    logic [RX_CW-1:0] rx_count_next;
    logic             rx_full;
    logic             rx_push;

    assign rx_full     = (rx_count_reg == RX_CW'(RX_DEPTH));
    assign rx_nonempty = (rx_count_reg != '0);
    // Held low during reset; otherwise driven from the pre-edge count
    assign io_rx_ready = !rx_full && !rst;
    assign rx_push     = io_rx_valid && io_rx_ready;
    assign rx_pop      = data_sel && !RWstate && rx_nonempty;
    assign rx_head     = rx_nonempty ? rx_mem[rx_rd_ptr_reg] : 8'h00;

    always_comb begin
        rx_count_next = rx_count_reg;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_next = rx_count_reg + 1'b1;
            2'b01:   rx_count_next = rx_count_reg - 1'b1;
            default: rx_count_next = rx_count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_ptr_reg] <= io_rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            rx_count_reg <= rx_count_next;
            if (rx_push)
                rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)
                rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
        end
    end
`else
    assign io_rx_ready = 1'b0;
    assign rx_nonempty = 1'b0;
    assign rx_head     = 8'h00;
    assign rx_pop      = 1'b0;

    wire unused_rx = &{1'b0, io_rx_valid, io_rx_data, rx_pop};
`endif

    // ------------------------------------------------------------------
    // Read data register (1-cycle latency, held on write cycles)
    // ------------------------------------------------------------------
    logic [7:0] io_read_next;

    always_comb begin
        io_read_next = 8'h00;
        if (data_sel)
            io_read_next = rx_head;
        else if (ctrl_sel)
            io_read_next = {5'b00000, tx_overflow_reg, tx_full, rx_nonempty};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ReadData <= 8'h00;
        end else if (!RWstate) begin
            if (is_io)
                ReadData <= io_read_next;
            else
                ReadData <= ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_ram_io.sv
// Directed self-checking bench for ram_io; inputs change after negedge, outputs checked at negedge.
// The RX scenario adapts to whether IO_RX_EN is defined.
module tb_ram_io;
    logic       clk = 1'b0;
    logic       rst;
    logic       RWstate;
    logic [31:0] RWaddr;
    logic [7:0] WrtData;
    logic [7:0] ReadData;
    logic       io_tx_valid;
    logic [7:0] io_tx_data;
    logic       io_tx_ready;
    logic       io_rx_valid;
    logic [7:0] io_rx_data;
    logic       io_rx_ready;
    logic       sim_halt;

    int tests_run = 0;
    int tests_failed = 0;

    ram_io dut (
        .clk(clk), .rst(rst),
        .RWstate(RWstate), .RWaddr(RWaddr), .WrtData(WrtData), .ReadData(ReadData),
        .io_tx_valid(io_tx_valid), .io_tx_data(io_tx_data), .io_tx_ready(io_tx_ready),
        .io_rx_valid(io_rx_valid), .io_rx_data(io_rx_data), .io_rx_ready(io_rx_ready),
        .sim_halt(sim_halt)
    );

    always #5 clk = ~clk;

    // One access per cycle: present inputs, let the posedge sample them, return at the next negedge
    task automatic cyc(input logic rw, input logic [31:0] addr, input logic [7:0] data);
        RWstate = rw;
        RWaddr  = addr;
        WrtData = data;
        @(negedge clk);
        RWstate = 1'b0;
        RWaddr  = 32'h0;
        WrtData = 8'h00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (ReadData !== 8'h00) begin tests_failed++; $display("FAIL reset_readdata got=%h exp=00", ReadData); end
        tests_run++;
        if (io_tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid got=%b exp=0", io_tx_valid); end
        tests_run++;
        if (io_rx_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_ready got=%b exp=0", io_rx_ready); end
        tests_run++;
        if (sim_halt !== 1'b0) begin tests_failed++; $display("FAIL reset_halt got=%b exp=0", sim_halt); end
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic test_ram;
        cyc(1'b1, 32'h0000_0010, 8'hA5);
        cyc(1'b0, 32'h0000_0010, 8'h00);
        tests_run++;
        if (ReadData !== 8'hA5) begin tests_failed++; $display("FAIL ram_a5 got=%h exp=a5", ReadData); end
        cyc(1'b1, 32'h0001_FFFF, 8'h3C);
        cyc(1'b1, 32'h0000_0005, 8'h11);
        cyc(1'b1, 32'h0000_0006, 8'h22);
        cyc(1'b0, 32'h0000_0005, 8'h00);
        tests_run++;
        if (ReadData !== 8'h11) begin tests_failed++; $display("FAIL ram_b2b_0 got=%h exp=11", ReadData); end
        cyc(1'b0, 32'h0000_0006, 8'h00);
        tests_run++;
        if (ReadData !== 8'h22) begin tests_failed++; $display("FAIL ram_b2b_1 got=%h exp=22", ReadData); end
        cyc(1'b0, 32'h0001_FFFF, 8'h00);
        tests_run++;
        if (ReadData !== 8'h3C) begin tests_failed++; $display("FAIL ram_top got=%h exp=3c", ReadData); end
        $display("[TB] ram read/write checked");
    endtask

    task automatic test_tx;
        io_tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) cyc(1'b1, 32'h0003_0000, 8'(i));
        tests_run++;
        if (io_tx_valid !== 1'b1 || io_tx_data !== 8'h01) begin
            tests_failed++; $display("FAIL tx_head got=%b/%h exp=1/01", io_tx_valid, io_tx_data);
        end
        cyc(1'b0, 32'h0003_0004, 8'h00);
        tests_run++;
        if (ReadData !== 8'h06) begin tests_failed++; $display("FAIL tx_status_full got=%h exp=06", ReadData); end
        io_tx_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tests_run++;
            if (io_tx_valid !== 1'b1 || io_tx_data !== 8'(k)) begin
                tests_failed++; $display("FAIL tx_stream_%0d got=%b/%h exp=1/%h", k, io_tx_valid, io_tx_data, 8'(k));
            end
            cyc(1'b0, 32'h0, 8'h00);
        end
        tests_run++;
        if (io_tx_valid !== 1'b0) begin tests_failed++; $display("FAIL tx_drained got=%b exp=0", io_tx_valid); end
        io_tx_ready = 1'b0;
        $display("[TB] tx fill/overflow/stream checked");
    endtask

    task automatic test_other_offsets;
        cyc(1'b0, 32'h0000_0010, 8'h00);
        cyc(1'b0, 32'h0003_0008, 8'h00);
        tests_run++;
        if (ReadData !== 8'h00) begin tests_failed++; $display("FAIL io_other_read got=%h exp=00", ReadData); end
        cyc(1'b1, 32'h0003_0008, 8'hEE);
        cyc(1'b0, 32'h0003_0004, 8'h00);
        tests_run++;
        if (ReadData !== 8'h04 || sim_halt !== 1'b0 || io_tx_valid !== 1'b0) begin
            tests_failed++; $display("FAIL io_other_write got=%h/%b/%b exp=04/0/0", ReadData, sim_halt, io_tx_valid);
        end
        $display("[TB] other offsets checked");
    endtask

`ifdef IO_RX_EN
    task automatic test_rx;
        tests_run++;
        if (io_rx_ready !== 1'b1) begin tests_failed++; $display("FAIL rx_ready_idle got=%b exp=1", io_rx_ready); end
        io_rx_valid = 1'b1;
        io_rx_data  = 8'h41;
        cyc(1'b0, 32'h0, 8'h00);
        io_rx_data  = 8'h42;
        cyc(1'b0, 32'h0, 8'h00);
        io_rx_valid = 1'b0;
        cyc(1'b0, 32'h0003_0004, 8'h00);
        tests_run++;
        if (ReadData !== 8'h05) begin tests_failed++; $display("FAIL rx_status_ne got=%h exp=05", ReadData); end
        cyc(1'b0, 32'h0003_0000, 8'h00);
        tests_run++;
        if (ReadData !== 8'h41) begin tests_failed++; $display("FAIL rx_pop0 got=%h exp=41", ReadData); end
        cyc(1'b0, 32'h0003_0000, 8'h00);
        tests_run++;
        if (ReadData !== 8'h42) begin tests_failed++; $display("FAIL rx_pop1 got=%h exp=42", ReadData); end
        cyc(1'b0, 32'h0003_0000, 8'h00);
        tests_run++;
        if (ReadData !== 8'h00) begin tests_failed++; $display("FAIL rx_pop_empty got=%h exp=00", ReadData); end
        cyc(1'b0, 32'h0003_0004, 8'h00);
        tests_run++;
        if (ReadData !== 8'h04) begin tests_failed++; $display("FAIL rx_status_empty got=%h exp=04", ReadData); end
        io_rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            io_rx_data = 8'h61 + 8'(i);
            cyc(1'b0, 32'h0, 8'h00);
        end
        tests_run++;
        if (io_rx_ready !== 1'b0) begin tests_failed++; $display("FAIL rx_full_ready got=%b exp=0", io_rx_ready); end
        io_rx_data = 8'h99;
        cyc(1'b0, 32'h0, 8'h00);
        io_rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0003_0000, 8'h00);
            tests_run++;
            if (ReadData !== 8'h61 + 8'(i)) begin
                tests_failed++; $display("FAIL rx_drain_%0d got=%h exp=%h", i, ReadData, 8'h61 + 8'(i));
            end
        end
        cyc(1'b0, 32'h0003_0000, 8'h00);
        tests_run++;
        if (ReadData !== 8'h00) begin tests_failed++; $display("FAIL rx_drain_empty got=%h exp=00", ReadData); end
        $display("[TB] rx path checked");
    endtask
`else
    task automatic test_rx;
        io_rx_valid = 1'b1;
        io_rx_data  = 8'h55;
        cyc(1'b0, 32'h0, 8'h00);
        tests_run++;
        if (io_rx_ready !== 1'b0) begin tests_failed++; $display("FAIL norx_ready got=%b exp=0", io_rx_ready); end
        cyc(1'b0, 32'h0000_0010, 8'h00);
        cyc(1'b0, 32'h0003_0000, 8'h00);
        tests_run++;
        if (ReadData !== 8'h00) begin tests_failed++; $display("FAIL norx_read got=%h exp=00", ReadData); end
        cyc(1'b0, 32'h0003_0004, 8'h00);
        tests_run++;
        if (ReadData !== 8'h04) begin tests_failed++; $display("FAIL norx_status got=%h exp=04", ReadData); end
        io_rx_valid = 1'b0;
        $display("[TB] rx disabled checked");
    endtask
`endif

    task automatic test_halt;
        tests_run++;
        if (sim_halt !== 1'b0) begin tests_failed++; $display("FAIL halt_before got=%b exp=0", sim_halt); end
        cyc(1'b1, 32'h0003_0004, 8'h00);
        tests_run++;
        if (sim_halt !== 1'b1) begin tests_failed++; $display("FAIL halt_set got=%b exp=1", sim_halt); end
        cyc(1'b1, 32'h0000_0030, 8'h12);
        cyc(1'b1, 32'h0003_0000, 8'h34);
        cyc(1'b0, 32'h0003_0004, 8'h00);
        cyc(1'b0, 32'h0000_0030, 8'h00);
        tests_run++;
        if (sim_halt !== 1'b1 || ReadData !== 8'h12) begin
            tests_failed++; $display("FAIL halt_held got=%b/%h exp=1/12", sim_halt, ReadData);
        end
        $display("[TB] halt checked");
    endtask

    task automatic test_reset_mid;
        io_tx_ready = 1'b0;
        cyc(1'b1, 32'h0000_0020, 8'h5C);
        cyc(1'b1, 32'h0003_0000, 8'hA1);
        cyc(1'b1, 32'h0003_0000, 8'hA2);
        cyc(1'b1, 32'h0003_0000, 8'hA3);
        cyc(1'b0, 32'h0000_0020, 8'h00);
        tests_run++;
        if (ReadData !== 8'h5C || io_tx_valid !== 1'b1) begin
            tests_failed++; $display("FAIL mid_before got=%h/%b exp=5c/1", ReadData, io_tx_valid);
        end
        RWaddr = 32'h0000_0020;
        rst = 1'b1;
        #1;
        tests_run++;
        if (io_tx_valid !== 1'b0 || ReadData !== 8'h00 || sim_halt !== 1'b0 || io_rx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset got=%b/%h/%b/%b exp=0/00/0/0", io_tx_valid, ReadData, sim_halt, io_rx_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 32'h0000_0020, 8'h00);
        tests_run++;
        if (ReadData !== 8'h5C || io_tx_valid !== 1'b0) begin
            tests_failed++; $display("FAIL mid_after got=%h/%b exp=5c/0", ReadData, io_tx_valid);
        end
        $display("[TB] reset mid-stream checked");
    endtask

    task automatic test_tx_simul;
        io_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h0003_0000, 8'h10 + 8'(i));
        cyc(1'b0, 32'h0003_0004, 8'h00);
        tests_run++;
        if (ReadData !== 8'h02) begin tests_failed++; $display("FAIL simul_full got=%h exp=02", ReadData); end
        io_tx_ready = 1'b1;
        cyc(1'b1, 32'h0003_0000, 8'h77);
        io_tx_ready = 1'b0;
        cyc(1'b0, 32'h0003_0004, 8'h00);
        tests_run++;
        if (ReadData !== 8'h02) begin tests_failed++; $display("FAIL simul_status got=%h exp=02", ReadData); end
        io_tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (io_tx_valid !== 1'b1 || io_tx_data !== ((k < 7) ? 8'h11 + 8'(k) : 8'h77)) begin
                tests_failed++;
                $display("FAIL simul_stream_%0d got=%b/%h exp=1/%h", k, io_tx_valid, io_tx_data,
                         (k < 7) ? 8'h11 + 8'(k) : 8'h77);
            end
            cyc(1'b0, 32'h0, 8'h00);
        end
        tests_run++;
        if (io_tx_valid !== 1'b0) begin tests_failed++; $display("FAIL simul_drained got=%b exp=0", io_tx_valid); end
        io_tx_ready = 1'b0;
        $display("[TB] tx push+pop when full checked");
    endtask

    initial begin
        rst         = 1'b1;
        RWstate     = 1'b0;
        RWaddr      = 32'h0;
        WrtData     = 8'h00;
        io_tx_ready = 1'b0;
        io_rx_valid = 1'b0;
        io_rx_data  = 8'h00;
        test_reset();
        test_ram();
        test_tx();
        test_other_offsets();
        test_rx();
        test_halt();
        test_reset_mid();
        test_tx_simul();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
